adc_qsys_onchip_mem_arbiter: RTL and testbench
==============================================

# adc_qsys_onchip_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port 8×32 on-chip RAM between two requesters: port 0, the ADC sample writer, and port 1, the CPU/bridge.
- Grants one transaction at a time, round-robin by default.
- Latches the winner's command and drives the RAM's chipselect/write/address/byteenable/writedata.
- Returns read data with the RAM's one-cycle registered-address latency.
- Sits between the requesters and the RAM's s1 slave inside adc_qsys.

## Interface
- ADDR_W, default 3: word address width (RAM depth 2^ADDR_W = 8).
- DATA_W, default 32: data width; must be a multiple of 8.
- BE_W, default DATA_W/8: byteenable width.

Ports (N = 0, 1):
- clk  in  1  single clock for all logic and the RAM.
- reset  in  1  asynchronous, active-high reset.
- rqN_read  in  1  read request; held until rqN_waitrequest is low.
- rqN_write  in  1  write request; held until rqN_waitrequest is low.
- rqN_address  in  ADDR_W  word address.
- rqN_byteenable  in  BE_W  byte lanes for writes.
- rqN_writedata  in  DATA_W  write data.
- rqN_readdata  out  DATA_W  read data; valid when rqN_read is high and rqN_waitrequest is low.
- rqN_waitrequest  out  1  low only in the cycle that completes port N's transaction.
- ram_chipselect  out  1  RAM select.
- ram_write  out  1  RAM write enable (qualified by ram_chipselect).
- ram_address  out  ADDR_W  RAM address.
- ram_byteenable  out  BE_W  RAM byte enables.
- ram_writedata  out  DATA_W  RAM write data.
- ram_readdata  in  DATA_W  RAM q; valid the cycle after the address is issued.

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE, no request on either port: stay in IDLE.
- IDLE, at least one request: select a winner and latch its port index, op, address, byteenable and writedata into command registers; go to ISSUE.
- ISSUE: drive the RAM from the command registers with ram_chipselect=1 and ram_write=op.
  - Write: drop the winner's waitrequest in this cycle; next state IDLE.
  - Read: next state RDATA.
- RDATA: ram_chipselect=0; rqW_readdata=ram_readdata; drop the winner's waitrequest; next state IDLE.
- Arbitration: the last_grant register records the last port served.
  - One requester: it wins.
  - Both requesting: the port other than last_grant wins.
  - last_grant updates on each grant.
- Read and write both high on one port: treated as a write; the read is ignored for that transaction.
- The loser keeps its waitrequest high and is served in the next arbitration. Fairness: each port waits at most one foreign transaction.
- The command is latched at grant, so input changes after grant do not affect the transaction in flight.
- rqN_readdata is 0 whenever port N is not completing a read.
- Outside ISSUE, ram_* outputs are 0.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - Command registers 0.
  - rqN_waitrequest=1, rqN_readdata=0, all ram_* outputs 0.
- Reset asserted mid-transaction: the transaction is aborted immediately with no completion pulse; the requester keeps seeing waitrequest high and reissues after reset.
- Write latency: request seen in IDLE at cycle T; RAM write and waitrequest low at T+1.
- Read latency: address issued at T+1; readdata and waitrequest low at T+2.
- Minimum turnaround: every transaction returns through IDLE, so there is at most one write per 2 cycles and one read per 3 cycles.
- There is no combinational path from rqN_* inputs to ram_* outputs; all RAM-side outputs decode from registered state.
- Address wrap: ADDR_W bits are passed through unmodified.

## Configuration
- ONCHIP_ARB_FIXED_PRIO_EN defined:
  - Port 0 always wins when both ports request; last_grant is not implemented.
  - Port 1 can starve while port 0 requests back-to-back.
- ONCHIP_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Test plan
- Single write: rq0_write with address 3, byteenable 0xF, data 0xDEADBEEF. Expect ram_write=1 at T+1 with rq0_waitrequest low for exactly that cycle. A later rq1_read of address 3 returns 0xDEADBEEF at T+2.
- Byte lanes: write 0x11223344 to address 5, then write 0xAABBCCDD with byteenable 0x5, then read address 5. Expect 0x11BB33DD.
- Contention: both ports issue writes continuously from reset.
  - Round-robin: completion order is 0,1,0,1…
  - With ONCHIP_ARB_FIXED_PRIO_EN: only port 0 completes while it requests.
- Command hold: rq1_read of address 7 is granted; rq1_address changes to 0 in ISSUE. Expect ram_address=7 and the data returned from address 7.
- Reset mid-read: assert reset in RDATA. Expect no waitrequest-low pulse, state IDLE, all outputs at reset values. The reissued read completes normally.
- Read+write collision: rq0_read=rq0_write=1 at address 2 with data 0x5A5A5A5A. Expect a single write completion at T+1 and no RDATA cycle.

Source files
------------

// File: rtl/adc_qsys_onchip_mem_arbiter.sv
// adc_qsys_onchip_mem_arbiter: two-port Avalon-MM arbiter in front of the single-port on-chip RAM.
// Round-robin by default; define ONCHIP_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module adc_qsys_onchip_mem_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_read,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_address,
  input  logic [BE_W-1:0]   rq0_byteenable,
  input  logic [DATA_W-1:0] rq0_writedata,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_waitrequest,
  input  logic              rq1_read,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_address,
  input  logic [BE_W-1:0]   rq1_byteenable,
  input  logic [DATA_W-1:0] rq1_writedata,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_waitrequest,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;
  state_t state;
  logic win;
  logic op;
  logic [ADDR_W-1:0] c_addr;
  logic [BE_W-1:0] c_be;
  logic [DATA_W-1:0] c_wd;
  logic req0, req1, pick, issue, done;
  assign req0 = rq0_read | rq0_write;
  assign req1 = rq1_read | rq1_write;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
  assign pick = ~req0;
`else
  logic last_grant;
  assign pick = (req0 & req1) ? ~last_grant : req1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      win <= 1'b0;
      op <= 1'b0;
      c_addr <= '0;
      c_be <= '0;
      c_wd <= '0;
`ifndef ONCHIP_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state <= ISSUE;
          win <= pick;
          // write takes precedence when read and write are both high
          op <= pick ? rq1_write : rq0_write;
          c_addr <= pick ? rq1_address : rq0_address;
          c_be <= pick ? rq1_byteenable : rq0_byteenable;
          c_wd <= pick ? rq1_writedata : rq0_writedata;
`ifndef ONCHIP_ARB_FIXED_PRIO_EN
          last_grant <= pick;
`endif
        end
        ISSUE: state <= op ? IDLE : RDATA;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    issue = state == ISSUE;
    done = (issue & op) | (state == RDATA);
    ram_chipselect = issue;
    ram_write = issue & op;
    ram_address = issue ? c_addr : '0;
    ram_byteenable = issue ? c_be : '0;
    ram_writedata = issue ? c_wd : '0;
    rq0_waitrequest = ~(done & ~win);
    rq1_waitrequest = ~(done & win);
    rq0_readdata = (state == RDATA && !win) ? ram_readdata : '0;
    rq1_readdata = (state == RDATA && win) ? ram_readdata : '0;
  end
endmodule

// File: tb/tb_adc_qsys_onchip_mem_arbiter.sv
// tb_adc_qsys_onchip_mem_arbiter: directed vectors, corner sequences and a transaction-level random model.
module tb_adc_qsys_onchip_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic rd[2], wr[2];
  logic [2:0] ad[2];
  logic [3:0] be[2];
  logic [31:0] wd[2];
  logic [31:0] rdata[2];
  logic wait_r[2];
  logic ram_chipselect, ram_write;
  logic [2:0] ram_address;
  logic [3:0] ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;
  logic [31:0] ram[8];
  logic [31:0] mm[8];
  int n_cmp = 0, n_bad = 0;

  adc_qsys_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .rq0_read(rd[0]), .rq0_write(wr[0]), .rq0_address(ad[0]), .rq0_byteenable(be[0]),
    .rq0_writedata(wd[0]), .rq0_readdata(rdata[0]), .rq0_waitrequest(wait_r[0]),
    .rq1_read(rd[1]), .rq1_write(wr[1]), .rq1_address(ad[1]), .rq1_byteenable(be[1]),
    .rq1_writedata(wd[1]), .rq1_readdata(rdata[1]), .rq1_waitrequest(wait_r[1]),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_address(ram_address),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    merge = o;
    for (int i = 0; i < 4; i++) if (b[i]) merge[i*8 +: 8] = n[i*8 +: 8];
  endfunction

  // RAM with registered address: q appears the cycle after the address
  always @(posedge clk) if (ram_chipselect) begin
    if (ram_write) ram[ram_address] <= merge(ram[ram_address], ram_writedata, ram_byteenable);
    ram_readdata <= ram[ram_address];
  end

  typedef struct {
    logic port, rd, wr;
    logic [2:0] addr;
    logic [3:0] be;
    logic [31:0] wd, exp;
    int lat;
  } vec_t;

  function automatic vec_t mk(input logic p, input logic r, input logic w, input logic [2:0] a,
                              input logic [3:0] b, input logic [31:0] d, input logic [31:0] e, input int l);
    mk.port = p; mk.rd = r; mk.wr = w; mk.addr = a; mk.be = b; mk.wd = d; mk.exp = e; mk.lat = l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int p = 0; p < 2; p++) begin
      rd[p] = 0; wr[p] = 0; ad[p] = 0; be[p] = 0; wd[p] = 0;
    end
  endtask

  task automatic xact(input vec_t v);
    int n;
    logic got;
    @(posedge clk); #1;
    rd[v.port] = v.rd; wr[v.port] = v.wr; ad[v.port] = v.addr; be[v.port] = v.be; wd[v.port] = v.wd;
    n = 0;
    got = 0;
    do begin
      @(negedge clk);
      n++;
      got = !wait_r[v.port];
      if (!got) begin @(posedge clk); #1; end
    end while (!got && n < 10);
    chk("xact_done", got, 1);
    if (got) begin
      chk("latency", n - 1, v.lat);
      chk("ram_write_at_done", ram_write, v.wr);
      chk("ram_cs_at_done", ram_chipselect, v.wr);
      chk("readdata", rdata[v.port], v.wr ? 32'h0 : v.exp);
      chk("other_wait", wait_r[!v.port], 1);
      if (v.wr) mm[v.addr] = merge(mm[v.addr], v.wd, v.be);
    end
    @(posedge clk); #1;
    clr();
    @(negedge clk);
    chk("wait_one_cycle", wait_r[v.port], 1);
  endtask

  vec_t tbl[7];
  vec_t v;
  int q[$];
  int busy, rem, wp, last, k;
  logic wop, done, iss, r0, r1;
  logic [2:0] wa;
  logic [3:0] wbe;
  logic [31:0] wdat;
  logic fin[2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(0, 0, 1, 3, 4'hF, 32'hDEADBEEF, 0, 1);
    tbl[1] = mk(1, 1, 0, 3, 4'h0, 32'h0, 32'hDEADBEEF, 2);
    tbl[2] = mk(0, 0, 1, 5, 4'hF, 32'h11223344, 0, 1);
    tbl[3] = mk(1, 0, 1, 5, 4'h5, 32'hAABBCCDD, 0, 1);
    tbl[4] = mk(0, 1, 0, 5, 4'h0, 32'h0, 32'h11BB33DD, 2);
    tbl[5] = mk(0, 1, 1, 2, 4'hF, 32'h5A5A5A5A, 0, 1);
    tbl[6] = mk(1, 1, 0, 2, 4'h0, 32'h0, 32'h5A5A5A5A, 2);
    reset = 1;
    clr();
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait0", wait_r[0], 1);
    chk("rst_wait1", wait_r[1], 1);
    chk("rst_rdata0", rdata[0], 0);
    chk("rst_rdata1", rdata[1], 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_we", ram_write, 0);
    chk("rst_addr", ram_address, 0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 8; i++) xact(mk(i[0], 0, 1, i[2:0], 4'hF, 32'hC0DE0000 + i, 0, 1));
    for (int i = 0; i < 7; i++) xact(tbl[i]);
    // command hold: address change after grant must not reach the RAM
    @(posedge clk); #1;
    rd[1] = 1; ad[1] = 7;
    @(negedge clk);
    @(posedge clk); #1;
    ad[1] = 0;
    @(negedge clk);
    chk("hold_cs", ram_chipselect, 1);
    chk("hold_addr", ram_address, 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_wait", wait_r[1], 0);
    chk("hold_data", rdata[1], mm[7]);
    @(posedge clk); #1;
    clr();
    // contention from reset
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    wr[0] = 1; ad[0] = 0; be[0] = 4'hF; wd[0] = 32'hA0A0A0A0;
    wr[1] = 1; ad[1] = 1; be[1] = 4'hF; wd[1] = 32'hB1B1B1B1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("one_done", (!wait_r[0] && !wait_r[1]), 0);
      if (!wait_r[0]) q.push_back(0);
      if (!wait_r[1]) q.push_back(1);
    end
    chk("cont_count", q.size() >= 8, 1);
    for (int i = 0; i < q.size(); i++) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      chk("cont_order", q[i], 0);
`else
      chk("cont_order", q[i], i % 2);
`endif
    end
    @(posedge clk); #1;
    clr();
    repeat (3) @(negedge clk);
    mm[0] = 32'hA0A0A0A0;
`ifndef ONCHIP_ARB_FIXED_PRIO_EN
    mm[1] = 32'hB1B1B1B1;
`endif
    // reset during RDATA: no completion pulse, requester reissues
    @(posedge clk); #1;
    rd[0] = 1; ad[0] = 4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    clr();
    @(negedge clk);
    chk("rstmid_wait0", wait_r[0], 1);
    chk("rstmid_wait1", wait_r[1], 1);
    chk("rstmid_rdata0", rdata[0], 0);
    chk("rstmid_cs", ram_chipselect, 0);
    chk("rstmid_addr", ram_address, 0);
    reset = 0;
    xact(mk(0, 1, 0, 4, 4'h0, 32'h0, mm[4], 2));
    // random traffic against a transaction-level model
    busy = 0; rem = 0; wp = 0; last = 0; wop = 0; wa = 0; wbe = 0; wdat = 0;
    fin[0] = 0; fin[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (fin[p]) begin rd[p] = 0; wr[p] = 0; fin[p] = 0; end
        if (!rd[p] && !wr[p]) begin
          if ($urandom_range(2) == 0) begin
            k = $urandom_range(3);
            rd[p] = (k != 2);
            wr[p] = (k >= 2);
            ad[p] = 3'($urandom);
            be[p] = 4'($urandom);
            wd[p] = $urandom;
          end
        end else if (busy != 0 && wp == p) begin
          ad[p] = 3'($urandom);
          be[p] = 4'($urandom);
          wd[p] = $urandom;
        end
      end
      @(negedge clk);
      done = 0;
      if (busy != 0) begin rem--; done = (rem == 0); end
      iss = (busy != 0) && (wop ? rem == 0 : rem == 1);
      for (int p = 0; p < 2; p++) begin
        chk("rnd_wait", wait_r[p], !(done && wp == p));
        chk("rnd_rdata", rdata[p], (done && wp == p && !wop) ? mm[wa] : 32'h0);
      end
      chk("rnd_cs", ram_chipselect, iss);
      chk("rnd_we", ram_write, iss && wop);
      chk("rnd_addr", ram_address, iss ? wa : 3'h0);
      chk("rnd_be", ram_byteenable, iss ? wbe : 4'h0);
      chk("rnd_wd", ram_writedata, iss ? wdat : 32'h0);
      r0 = rd[0] | wr[0];
      r1 = rd[1] | wr[1];
      if (done) begin
        if (wop) mm[wa] = merge(mm[wa], wdat, wbe);
        busy = 0;
        fin[wp] = 1;
      end else if (busy == 0 && (r0 || r1)) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
        wp = r0 ? 0 : 1;
`else
        wp = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
`endif
        last = wp;
        wop = wr[wp]; wa = ad[wp]; wbe = be[wp]; wdat = wd[wp];
        busy = 1;
        rem = wop ? 1 : 2;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
